// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 little-endian byte packer; used for both the length header and program words.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // Bytes shift in from the top so the first byte ends up in [7:0] after four shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else begin
            if (clear) begin
                byte_cnt <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (accept) begin
                shreg <= {byte_in, shreg[31:8]};
            end
        end
    end

    // The complete word is presented combinationally in the same cycle as its 4th byte.
    assign word       = {byte_in, shreg[31:8]};
    assign word_valid = accept && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed byte stream, writes words to instruction
// memory and keeps the CPU in reset until the whole program is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                honour_start;
    logic                word_valid;
    logic [31:0]         word;
    logic                data_word;
    logic [31:0]         len;
    logic [ADDR_WIDTH:0] word_idx;
    logic [31:0]         idx_ext;
    logic                last_word;
    logic                len_oversize;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (honour_start),
        .accept     (accept),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign in_ready     = (state == ST_LEN) || (state == ST_DATA);
    assign accept       = in_valid && in_ready;
    assign honour_start = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                    (state == ST_ERROR));
    assign data_word    = word_valid && (state == ST_DATA);

    assign idx_ext      = 32'(word_idx);
    assign last_word    = (idx_ext + 32'd1) == len;
    // 33-bit compare so a header of 0xFFFF_FFFF cannot alias to a legal size.
    assign len_oversize = {1'b0, word} > MAX_WORDS;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DATA leaves for DONE on the edge that accepts the last byte.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0)     state_nxt = ST_DONE;
                    else if (len_oversize) state_nxt = ST_ERROR;
                    else                   state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_word && last_word) state_nxt = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_nxt = ST_LEN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Length capture, word counter and the registered one-cycle memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= 32'd0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= data_word;
            if (honour_start) begin
                word_idx <= '0;
            end
            if ((state == ST_LEN) && word_valid) begin
                len <= word;
            end
            if (data_word) begin
                imem_addr  <= BASE_ADDR + (idx_ext << 2);
                imem_wdata <= word;
                word_idx   <= word_idx + 1'b1;
            end
        end
    end

    // The CPU is released only once DONE is reached and no write is still in flight.
    assign cpu_rst = !((state == ST_DONE) && !imem_we);
    assign busy    = in_ready;
    assign done    = (state == ST_DONE);
    assign error   = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (AW=10/base 0, AW=4/base 0x100).
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_g = 1'b0;
    logic       in_valid_g = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       sel0 = 1'b1;
    logic       sel1 = 1'b1;

    logic        rdy0, we0, crst0, busy0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        rdy1, we1, crst1, busy1, done1, err1;
    logic [31:0] addr1, wd1;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .start(start_g & sel0), .in_valid(in_valid_g & sel0),
        .in_data(in_data), .in_ready(rdy0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wd0), .cpu_rst(crst0), .busy(busy0), .done(done0), .error(err0));

    imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst), .start(start_g & sel1), .in_valid(in_valid_g & sel1),
        .in_data(in_data), .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wd1), .cpu_rst(crst1), .busy(busy1), .done(done1), .error(err1));

    int total = 0;
    int bad = 0;
    int gap_pct = 0;
    bit mid_start = 1'b0;
    logic [31:0] words [0:31];
    logic [31:0] wa0 [$];
    logic [31:0] wdq0 [$];
    logic [31:0] wa1 [$];
    logic [31:0] wdq1 [$];

    typedef struct {
        logic [31:0] len;
        int          nw;
        logic [31:0] seed;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;
    vec_t vecs [6];

    // Write monitor: each strobe cycle is seen exactly once on the falling edge.
    always @(negedge clk) begin
        if (we0) begin wa0.push_back(addr0); wdq0.push_back(wd0); end
        if (we1) begin wa1.push_back(addr1); wdq1.push_back(wd1); end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flags0();
        return {26'd0, rdy0, we0, crst0, busy0, done0, err0};
    endfunction

    function automatic logic [31:0] flags1();
        return {26'd0, rdy1, we1, crst1, busy1, done1, err1};
    endfunction

    function automatic logic ready_sel();
        return (!sel0 || rdy0) && (!sel1 || rdy1);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid_g = 1'b0;
            in_data    = 8'($urandom);
            start_g    = mid_start && ($urandom_range(3) == 0);
            @(negedge clk);
        end
        start_g    = 1'b0;
        in_valid_g = 1'b1;
        in_data    = b;
        n = 0;
        while (!ready_sel()) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                chk("ready_timeout", 32'(ready_sel()), 32'd1);
                break;
            end
        end
        @(negedge clk);
        in_valid_g = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic clear_q();
        wa0.delete(); wdq0.delete(); wa1.delete(); wdq1.delete();
    endtask

    // Returns on the falling edge right after the last byte is taken.
    task automatic do_load(input logic [31:0] len, input int nw);
        clear_q();
        start_g = 1'b1;
        @(negedge clk);
        start_g = 1'b0;
        send_word(len);
        for (int i = 0; i < nw; i++) send_word(words[i]);
    endtask

    // Reference: a legal length L yields writes base+4*i <- words[i] for i < L.
    task automatic check_writes(input int which, input logic [31:0] len, input int aw,
                                input logic [31:0] base, input string tag);
        logic [31:0] qa [$];
        logic [31:0] qd [$];
        longint n;
        if (which == 0) begin qa = wa0; qd = wdq0; end
        else            begin qa = wa1; qd = wdq1; end
        n = (longint'(len) <= (longint'(1) << aw)) ? longint'(len) : 0;
        chk({tag, "_count"}, 32'(qa.size()), 32'(n));
        for (int i = 0; i < int'(n) && i < qa.size(); i++) begin
            chk({tag, "_addr"}, qa[i], base + 32'(4 * i));
            chk({tag, "_data"}, qd[i], words[i]);
        end
    endtask

    initial begin
        vecs[0] = '{32'd17,         0,  32'h0,         1'b0, 1'b1, 0};
        vecs[1] = '{32'd1,          1,  32'hDEADBEEF,  1'b1, 1'b0, 1};
        vecs[2] = '{32'hFFFF_FFFF,  0,  32'h0,         1'b0, 1'b1, 0};
        vecs[3] = '{32'd16,         16, 32'h1234_5678, 1'b1, 1'b0, 16};
        vecs[4] = '{32'd0,          0,  32'h0,         1'b1, 1'b0, 0};
        vecs[5] = '{32'd3,          3,  32'hA5A5_0001, 1'b1, 1'b0, 3};

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_flags0", flags0(), 32'b001000);
        chk("rst_flags1", flags1(), 32'b001000);
        chk("rst_addr1", addr1, 32'h0);
        chk("rst_wdata1", wd1, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_flags0", flags0(), 32'b001000);

        // Two-word load on both instances.
        words[0] = 32'h0050_0513;
        words[1] = 32'h00a0_0593;
        do_load(32'd2, 2);
        chk("w2_last_flags0", flags0(), 32'b011010);
        chk("w2_last_addr0", addr0, 32'h4);
        chk("w2_last_data0", wd0, 32'h00a0_0593);
        chk("w2_last_addr1", addr1, 32'h104);
        @(negedge clk);
        chk("w2_after_flags0", flags0(), 32'b000010);
        chk("w2_after_flags1", flags1(), 32'b000010);
        check_writes(0, 32'd2, 10, 32'h0, "w2_d0");
        check_writes(1, 32'd2, 4, 32'h100, "w2_d1");

        // Zero-length program: release straight away with no write.
        do_load(32'd0, 0);
        chk("len0_flags0", flags0(), 32'b000010);
        repeat (2) @(negedge clk);
        chk("len0_count0", 32'(wa0.size()), 32'd0);

        // Table-driven loads on the small instance only (oversize, boundaries, reload).
        sel0 = 1'b0;
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].nw; i++) words[i] = vecs[v].seed ^ (32'(i) * 32'h9E37_79B9);
            do_load(vecs[v].len, vecs[v].nw);
            repeat (2) @(negedge clk);
            chk("vec_done", 32'(done1), 32'(vecs[v].exp_done));
            chk("vec_error", 32'(err1), 32'(vecs[v].exp_err));
            chk("vec_cpu_rst", 32'(crst1), 32'(vecs[v].exp_err));
            chk("vec_in_ready", 32'(rdy1), 32'd0);
            chk("vec_writes", 32'(wa1.size()), 32'(vecs[v].exp_writes));
            for (int i = 0; i < vecs[v].exp_writes && i < wa1.size(); i++) begin
                chk("vec_addr", wa1[i], 32'h100 + 32'(4 * i));
                chk("vec_data", wdq1[i], vecs[v].seed ^ (32'(i) * 32'h9E37_79B9));
            end
        end
        sel0 = 1'b1;

        // Randomised loads with input gaps and ignored mid-load start pulses.
        gap_pct   = 40;
        mid_start = 1'b1;
        for (int r = 0; r < 12; r++) begin
            logic [31:0] len;
            len = 32'($urandom_range(0, 5));
            for (int i = 0; i < 5; i++) words[i] = $urandom;
            do_load(len, int'(len));
            repeat (2) @(negedge clk);
            check_writes(0, len, 10, 32'h0, "rnd_d0");
            check_writes(1, len, 4, 32'h100, "rnd_d1");
            chk("rnd_done0", 32'(done0), 32'd1);
            chk("rnd_cpu_rst1", 32'(crst1), 32'd0);
        end
        gap_pct   = 0;
        mid_start = 1'b0;

        // Reset in the middle of a load: 6 data bytes, then asynchronous rst.
        clear_q();
        start_g = 1'b1;
        @(negedge clk);
        start_g = 1'b0;
        send_word(32'd3);
        send_word(32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        rst = 1'b1;
        #1;
        chk("mid_rst_flags0", flags0(), 32'b001000);
        chk("mid_rst_flags1", flags1(), 32'b001000);
        chk("mid_rst_addr1", addr1, 32'h0);
        chk("mid_rst_wdata0", wd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_flags1", flags1(), 32'b001000);
        words[0] = 32'hCAFE_0001;
        words[1] = 32'hCAFE_0002;
        do_load(32'd2, 2);
        repeat (2) @(negedge clk);
        check_writes(1, 32'd2, 4, 32'h100, "fresh_d1");
        check_writes(0, 32'd2, 10, 32'h0, "fresh_d0");

        // Reload from DONE: CPU goes back into reset during the load.
        clear_q();
        start_g = 1'b1;
        @(negedge clk);
        start_g = 1'b0;
        chk("reload_len_flags1", flags1(), 32'b101100);
        words[0] = 32'hDEAD_BEEF;
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        chk("reload_last_flags1", flags1(), 32'b011010);
        @(negedge clk);
        chk("reload_after_flags1", flags1(), 32'b000010);
        @(negedge clk);
        check_writes(1, 32'd1, 4, 32'h100, "reload_d1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
